// File: rtl/beamformer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beamformer_seq_pkg
// Purpose  : Shared constants for the beamformer sequencer: default bus
//            widths and the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package beamformer_seq_pkg;

    // Default widths of the beamformer address and sum buses.
    localparam int c_def_addr_w = 11;
    localparam int c_def_data_w = 12;

    // Controller state encoding.
    localparam int c_state_w = 3;
    localparam logic [c_state_w-1:0] c_st_idle       = 3'd0;
    localparam logic [c_state_w-1:0] c_st_load_wait  = 3'd1;
    localparam logic [c_state_w-1:0] c_st_readin     = 3'd2;
    localparam logic [c_state_w-1:0] c_st_drain      = 3'd3;
    localparam logic [c_state_w-1:0] c_st_so_wait    = 3'd4;
    localparam logic [c_state_w-1:0] c_st_so_present = 3'd5;
    localparam logic [c_state_w-1:0] c_st_done       = 3'd6;

endpackage : beamformer_seq_pkg
`default_nettype wire

// File: rtl/beamformer_sequencer_flag_fall_detect.sv
`default_nettype none
// ============================================================================
// Module   : flag_fall_detect
// Purpose  : Registered falling-edge detector. The flag is sampled twice;
//            a fall (previous sample 1, current sample 0) produces a
//            one-cycle pulse, gated by the enable.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_en            - qualifies the output pulse
//            i_flag          - asynchronous-to-FSM flag from the beamformer
//            o_fall          - one-cycle fall pulse
// Revision : 1.0 - initial release
// ============================================================================
module flag_fall_detect
    import beamformer_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_flag,
    output logic o_fall
);

    logic r_cur;
    logic r_prev;

    // The sample history keeps running regardless of the enable so that a
    // fall straddling the enable boundary is judged on real history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_cur  <= i_flag;
            r_prev <= r_cur;
        end
    end

    assign o_fall = i_en & r_prev & ~r_cur;

endmodule : flag_fall_detect
`default_nettype wire

// File: rtl/beamformer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : beamformer_sequencer
// Purpose  : Sequences one capture of the delay-and-sum BRAM beamformer:
//            settle wait, sample read-in with write-pointer tracking from
//            usedataflag falls, a drain window, then sum read-out streamed
//            over a valid/ready interface.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            start / busy / done      - capture request and status
//            bf_*                     - beamformer control and data
//            out_data/valid/ready     - read-out stream
//            sum_count                - sums recorded in this/last capture
// Revision : 1.0 - initial release
// ============================================================================
module beamformer_sequencer
    import beamformer_seq_pkg::*;
#(
    parameter int ADDR_W       = c_def_addr_w,
    parameter int DATA_W       = c_def_data_w,
    parameter int NUM_SAMPLES  = 300,
    parameter int LOAD_DELAY   = 10,
    parameter int DRAIN_CYCLES = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bf_readin_address,
    output logic [ADDR_W-1:0] bf_sumout_address,
    output logic              bf_startbeamformer,
    output logic              bf_readinen,
    output logic              bf_sumouten,
    input  logic [DATA_W-1:0] bf_output_value,
    input  logic              bf_usedataflag,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   sum_count
);

    localparam int c_tmr_w = 16;
    localparam logic [c_tmr_w-1:0] c_load_last  = c_tmr_w'(LOAD_DELAY - 1);
    localparam logic [c_tmr_w-1:0] c_drain_last = c_tmr_w'(DRAIN_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_lat_last   = c_tmr_w'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0]  c_last_rd    = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [ADDR_W:0]    c_cnt_max    = (ADDR_W+1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]    c_cnt_one    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]  c_addr_one   = ADDR_W'(1);
    localparam logic [c_tmr_w-1:0] c_tmr_one    = c_tmr_w'(1);

    logic [c_state_w-1:0] r_state;
    logic [c_tmr_w-1:0]   r_timer;
    logic [ADDR_W-1:0]    r_readin_addr;
    logic [ADDR_W-1:0]    r_sumout_addr;
    logic [ADDR_W:0]      r_sum_count;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_startbf;
    logic                 r_readinen;
    logic                 r_sumouten;

    logic w_track_en;
    logic w_fall;
    logic w_cnt_inc;
    logic w_have_sums;
    logic w_last_word;

    // Write-pointer tracking is only meaningful while samples are flowing.
    assign w_track_en = (r_state == c_st_readin) || (r_state == c_st_drain);

    flag_fall_detect u_fall_detect (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_track_en),
        .i_flag (bf_usedataflag),
        .o_fall (w_fall)
    );

    assign w_cnt_inc   = w_fall && (r_sum_count != c_cnt_max);
    // A fall landing in the very last drain cycle still counts toward the
    // decision whether there is anything to read out.
    assign w_have_sums = (r_sum_count != '0) || w_cnt_inc;
    assign w_last_word = ({1'b0, r_sumout_addr} == (r_sum_count - c_cnt_one));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_timer       <= '0;
            r_readin_addr <= '0;
            r_sumout_addr <= '0;
            r_sum_count   <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_startbf     <= 1'b0;
            r_readinen    <= 1'b1;
            r_sumouten    <= 1'b0;
        end else begin
            // Sum tracking; the address saturates at its top value instead of
            // wrapping, the count saturates at 2^ADDR_W. Transitions below may
            // override the address.
            if (w_cnt_inc) begin
                r_sum_count <= r_sum_count + c_cnt_one;
                if (r_sumout_addr != '1) begin
                    r_sumout_addr <= r_sumout_addr + c_addr_one;
                end
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state       <= c_st_load_wait;
                        r_timer       <= '0;
                        r_sum_count   <= '0;
                        r_sumout_addr <= '0;
                        r_busy        <= 1'b1;
                    end
                end
                c_st_load_wait: begin
                    if (r_timer == c_load_last) begin
                        r_state       <= c_st_readin;
                        r_readin_addr <= '0;
                        r_startbf     <= 1'b1;
                        r_readinen    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_tmr_one;
                    end
                end
                c_st_readin: begin
                    if (r_readin_addr == c_last_rd) begin
                        r_state <= c_st_drain;
                        r_timer <= '0;
                    end else begin
                        r_readin_addr <= r_readin_addr + c_addr_one;
                    end
                end
                c_st_drain: begin
                    if (r_timer == c_drain_last) begin
                        r_timer   <= '0;
                        r_startbf <= 1'b0;
                        if (w_have_sums) begin
                            r_state       <= c_st_so_wait;
                            r_readinen    <= 1'b0;
                            r_sumouten    <= 1'b1;
                            r_sumout_addr <= '0;
                        end else begin
                            r_state <= c_st_done;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + c_tmr_one;
                    end
                end
                c_st_so_wait: begin
                    if (r_timer == c_lat_last) begin
                        r_state     <= c_st_so_present;
                        r_out_data  <= bf_output_value;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_tmr_one;
                    end
                end
                c_st_so_present: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_word) begin
                            r_state    <= c_st_done;
                            r_done     <= 1'b1;
                            r_sumouten <= 1'b0;
                            r_readinen <= 1'b1;
                        end else begin
                            r_state       <= c_st_so_wait;
                            r_timer       <= '0;
                            r_sumout_addr <= r_sumout_addr + c_addr_one;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_startbf   <= 1'b0;
                    r_sumouten  <= 1'b0;
                    r_readinen  <= 1'b1;
                end
            endcase
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign bf_readin_address  = r_readin_addr;
    assign bf_sumout_address  = r_sumout_addr;
    assign bf_startbeamformer = r_startbf;
    assign bf_readinen        = r_readinen;
    assign bf_sumouten        = r_sumouten;
    assign out_data           = r_out_data;
    assign out_valid          = r_out_valid;
    assign sum_count          = r_sum_count;

endmodule : beamformer_sequencer
`default_nettype wire

// File: tb/tb_beamformer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_beamformer_sequencer
// Purpose  : Directed self-checking bench for beamformer_sequencer. A default
//            instance covers timing, read-out, backpressure, ignored starts
//            and mid-capture reset; a small ADDR_W=2 instance covers count
//            saturation. The BRAM is modelled as an asynchronous read whose
//            contents are a fixed function of the address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beamformer_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [11:0] exp_word(input int a);
        return 12'((a * 291 + 7) % 4096);
    endfunction

    // Default instance
    logic        start = 1'b0, usedataflag = 1'b0, out_ready = 1'b1;
    logic        busy, done, startbf, readinen, sumouten, out_valid;
    logic [10:0] readin_addr, sumout_addr;
    logic [11:0] bf_value, out_data;
    logic [11:0] sum_count;

    assign bf_value = exp_word(int'(sumout_addr));

    beamformer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .bf_readin_address(readin_addr), .bf_sumout_address(sumout_addr),
        .bf_startbeamformer(startbf), .bf_readinen(readinen),
        .bf_sumouten(sumouten), .bf_output_value(bf_value),
        .bf_usedataflag(usedataflag), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sum_count(sum_count)
    );

    // Small instance for saturation
    logic        s_start = 1'b0, s_flag = 1'b0, s_ready = 1'b1;
    logic        s_busy, s_done, s_startbf, s_readinen, s_sumouten, s_valid;
    logic [1:0]  s_readin_addr, s_sumout_addr;
    logic [11:0] s_value, s_out_data;
    logic [2:0]  s_sum_count;

    assign s_value = exp_word(int'(s_sumout_addr));

    beamformer_sequencer #(.ADDR_W(2), .DATA_W(12), .NUM_SAMPLES(4)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .bf_readin_address(s_readin_addr), .bf_sumout_address(s_sumout_addr),
        .bf_startbeamformer(s_startbf), .bf_readinen(s_readinen),
        .bf_sumouten(s_sumouten), .bf_output_value(s_value),
        .bf_usedataflag(s_flag), .out_data(s_out_data),
        .out_valid(s_valid), .out_ready(s_ready), .sum_count(s_sum_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: start at cycle 0, usedataflag high for two cycles in
    // each of n_falls 40-cycle blocks of READIN, optional start poke at
    // READIN index poke_idx. Returns in the last DRAIN cycle (cycle 318).
    task automatic run_readin(input int n_falls, input int poke_idx);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 300; i++) begin
            usedataflag = ((i / 40) < n_falls) && ((i % 40) == 10 || (i % 40) == 11);
            start       = (i == poke_idx);
            tick();
        end
        usedataflag = 1'b0;
        start       = 1'b0;
        repeat (7) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, startbf, readinen, sumouten, out_valid} !== 6'b000100) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000100",
                     {busy, done, startbf, readinen, sumouten, out_valid});
        end
        checks++;
        if ({readin_addr, sumout_addr, sum_count, out_data} !== 46'd0) begin
            errors++;
            $display("FAIL reset_data got ra=%0d sa=%0d cnt=%0d od=%0h exp all 0",
                     readin_addr, sumout_addr, sum_count, out_data);
        end
        checks++;
        if ({s_busy, s_readinen, s_sum_count} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_small got %b exp 01000", {s_busy, s_readinen, s_sum_count});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_no_flags();
        logic [16:0] got, expv;
        logic [10:0] ra;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 320; c++) begin
            ra   = (c < 11) ? 11'd0 : ((c <= 310) ? 11'(c - 11) : 11'd299);
            expv = {(c <= 319), (c == 319), (c >= 11 && c <= 318), 1'b1, 1'b0, 1'b0, ra};
            got  = {busy, done, startbf, readinen, sumouten, out_valid, readin_addr};
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL no_flags_cycle%0d got %h exp %h", c, got, expv);
            end
            tick();
        end
        checks++;
        if (sum_count !== 12'd0) begin
            errors++;
            $display("FAIL no_flags_count got %0d exp 0", sum_count);
        end
    endtask

    task automatic test_sums();
        run_readin(5, -1);
        checks++;
        if ({sum_count, sumout_addr} !== {12'd5, 11'd5}) begin
            errors++;
            $display("FAIL sums_track got cnt=%0d sa=%0d exp 5 5", sum_count, sumout_addr);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({out_valid, sumouten, readinen, startbf, sumout_addr} !== {4'b0100, 11'(k)}) begin
                errors++;
                $display("FAIL sums_wait%0d got v=%b so=%b ri=%b sb=%b sa=%0d exp 0 1 0 0 %0d",
                         k, out_valid, sumouten, readinen, startbf, sumout_addr, k);
            end
            tick();
            checks++;
            if ({out_valid, out_data, sumout_addr} !== {1'b1, exp_word(k), 11'(k)}) begin
                errors++;
                $display("FAIL sums_word%0d got v=%b d=%0h sa=%0d exp 1 %0h %0d",
                         k, out_valid, out_data, sumout_addr, exp_word(k), k);
            end
            tick();
        end
        checks++;
        if ({done, busy, out_valid, sumouten, readinen} !== 5'b11001) begin
            errors++;
            $display("FAIL sums_done got %b exp 11001", {done, busy, out_valid, sumouten, readinen});
        end
        tick();
        checks++;
        if ({done, busy, sum_count} !== {2'b00, 12'd5}) begin
            errors++;
            $display("FAIL sums_idle got d=%b b=%b cnt=%0d exp 0 0 5", done, busy, sum_count);
        end
    endtask

    task automatic test_backpressure();
        run_readin(5, -1);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({out_valid, out_data, sumout_addr} !== {1'b1, exp_word(k), 11'(k)}) begin
                errors++;
                $display("FAIL bp_word%0d got v=%b d=%0h sa=%0d exp 1 %0h %0d",
                         k, out_valid, out_data, sumout_addr, exp_word(k), k);
            end
            if (k == 2) begin
                out_ready = 1'b0;
                for (int j = 0; j < 7; j++) begin
                    tick();
                    checks++;
                    if ({out_valid, out_data, sumout_addr} !== {1'b1, exp_word(2), 11'd2}) begin
                        errors++;
                        $display("FAIL bp_hold%0d got v=%b d=%0h sa=%0d exp 1 %0h 2",
                                 j, out_valid, out_data, sumout_addr, exp_word(2));
                    end
                end
                out_ready = 1'b1;
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        run_readin(3, 50);
        checks++;
        if ({busy, startbf, readin_addr, sum_count} !== {2'b11, 11'd299, 12'd3}) begin
            errors++;
            $display("FAIL ign_readin got b=%b sb=%b ra=%0d cnt=%0d exp 1 1 299 3",
                     busy, startbf, readin_addr, sum_count);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out_valid, out_data, sumout_addr} !== {1'b1, exp_word(k), 11'(k)}) begin
                errors++;
                $display("FAIL ign_word%0d got v=%b d=%0h sa=%0d exp 1 %0h %0d",
                         k, out_valid, out_data, sumout_addr, exp_word(k), k);
            end
            start = (k == 1);
            tick();
            start = 1'b0;
        end
        checks++;
        if ({done, sum_count} !== {1'b1, 12'd3}) begin
            errors++;
            $display("FAIL ign_done got d=%b cnt=%0d exp 1 3", done, sum_count);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_queue got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (110) tick();
        checks++;
        if ({startbf, readin_addr} !== {1'b1, 11'd100}) begin
            errors++;
            $display("FAIL rmid_pre got sb=%b ra=%0d exp 1 100", startbf, readin_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, startbf, readinen, sumouten, out_valid, readin_addr, sumout_addr, sum_count}
            !== {6'b000100, 34'd0}) begin
            errors++;
            $display("FAIL rmid_reset got b=%b d=%b sb=%b ri=%b so=%b v=%b ra=%0d sa=%0d cnt=%0d",
                     busy, done, startbf, readinen, sumouten, out_valid,
                     readin_addr, sumout_addr, sum_count);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL rmid_quiet%0d got d=%b b=%b exp 0 0", j, done, busy);
            end
        end
        run_readin(2, -1);
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({out_valid, out_data} !== {1'b1, exp_word(k)}) begin
                errors++;
                $display("FAIL rmid_word%0d got v=%b d=%0h exp 1 %0h", k, out_valid, out_data, exp_word(k));
            end
            tick();
        end
        checks++;
        if ({done, sum_count} !== {1'b1, 12'd2}) begin
            errors++;
            $display("FAIL rmid_done got d=%b cnt=%0d exp 1 2", done, sum_count);
        end
        tick();
    endtask

    task automatic test_saturate();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        // Flag high on even cycles 10..20 gives six falls seen in cycles 12..22.
        for (int c = 1; c <= 21; c++) begin
            s_flag = (c >= 10) && (c <= 20) && (c % 2 == 0);
            tick();
        end
        s_flag = 1'b0;
        checks++;
        if ({s_startbf, s_readin_addr, s_sum_count, s_sumout_addr} !== {1'b1, 2'd3, 3'd4, 2'd3}) begin
            errors++;
            $display("FAIL sat_track got sb=%b ra=%0d cnt=%0d sa=%0d exp 1 3 4 3",
                     s_startbf, s_readin_addr, s_sum_count, s_sumout_addr);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({s_valid, s_sumouten, s_sumout_addr} !== {2'b01, 2'(k)}) begin
                errors++;
                $display("FAIL sat_wait%0d got v=%b so=%b sa=%0d exp 0 1 %0d",
                         k, s_valid, s_sumouten, s_sumout_addr, k);
            end
            tick();
            checks++;
            if ({s_valid, s_out_data} !== {1'b1, exp_word(k)}) begin
                errors++;
                $display("FAIL sat_word%0d got v=%b d=%0h exp 1 %0h", k, s_valid, s_out_data, exp_word(k));
            end
            tick();
        end
        checks++;
        if ({s_done, s_sum_count} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL sat_done got d=%b cnt=%0d exp 1 4", s_done, s_sum_count);
        end
        tick();
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_idle got busy=%b exp 0", s_busy);
        end
    endtask

    initial begin
        test_reset();
        test_no_flags();
        test_sums();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule : tb_beamformer_sequencer
`default_nettype wire
